// File: rtl/ysyx_issue_pkg.sv
// Shared types and constants for the issue controller.
//   issue_state_t : serialisation FSM states (RUN=0, DRAIN=1, SERIAL=2)
//   ISSUE_CNT_W   : width of the in-flight counter
package ysyx_issue_pkg;

  localparam int unsigned ISSUE_CNT_W = 4;

  typedef enum logic [1:0] {
    IS_RUN    = 2'd0,
    IS_DRAIN  = 2'd1,
    IS_SERIAL = 2'd2
  } issue_state_t;

endpackage

// File: rtl/ysyx_issue_scoreboard.sv
// Register busy scoreboard for the issue controller.
//   clock, reset    : clock and asynchronous active-low reset
//   flush           : clears every busy bit next cycle (highest priority)
//   set_en/set_idx  : mark a destination busy on issue
//   clr_en/clr_idx  : release a destination on writeback (set wins on same index)
//   rs1/rs2/rd_idx  : combinational lookups of the registered busy bits
//   busy_map        : full busy vector, bit 0 hard-wired to 0
module ysyx_issue_scoreboard #(
  parameter int unsigned REG_LEN = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  set_en,
  input  logic [REG_LEN-1:0]    set_idx,
  input  logic                  clr_en,
  input  logic [REG_LEN-1:0]    clr_idx,
  input  logic [REG_LEN-1:0]    rs1_idx,
  input  logic [REG_LEN-1:0]    rs2_idx,
  input  logic [REG_LEN-1:0]    rd_idx,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy,
  output logic [2**REG_LEN-1:0] busy_map
);

  localparam int unsigned NumRegs = 2 ** REG_LEN;

  logic [NumRegs-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    // Applied after the clear so a same-cycle set of the same index wins.
    if (set_en) busy_d[set_idx] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Bit 0 is never set, so lookups of x0 read as free without an explicit index check.
  assign rs1_busy = busy_q[rs1_idx];
  assign rs2_busy = busy_q[rs2_idx];
  assign rd_busy  = busy_q[rd_idx];
  assign busy_map = busy_q;

endmodule

// File: rtl/ysyx_issue_ctrl.sv
// Issue controller between decode and execute.
// Gates decoded instructions onto the execute bus using a register scoreboard
// (RAW/WAW), an in-flight counter and a serialisation FSM that drains the
// pipeline before system-class instructions and holds issue until they retire.
//   clock, reset                 : clock and asynchronous active-low reset
//   in_valid/in_ready + fields   : decoded instruction from decode
//   out_valid/out_ready          : zero-latency handshake to execute
//   wb_valid/wb_rd               : writeback releases a busy register
//   cmt_valid                    : one instruction retires
//   flush                        : redirect/trap, clears all bookkeeping
//   busy_map, inflight, state    : debug visibility of internal state
module ysyx_issue_ctrl
  import ysyx_issue_pkg::*;
#(
  parameter int unsigned REG_LEN      = 4,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_LEN-1:0]     in_rs1,
  input  logic [REG_LEN-1:0]     in_rs2,
  input  logic                   in_use_rs1,
  input  logic                   in_use_rs2,
  input  logic [REG_LEN-1:0]     in_rd,
  input  logic                   in_serial,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   wb_valid,
  input  logic [REG_LEN-1:0]     wb_rd,
  input  logic                   cmt_valid,
  input  logic                   flush,
  output logic [2**REG_LEN-1:0]  busy_map,
  output logic [ISSUE_CNT_W-1:0] inflight,
  output logic [1:0]             state
);

  issue_state_t           state_q, state_d;
  logic [ISSUE_CNT_W-1:0] inflight_q, inflight_d;

  logic rs1_busy, rs2_busy, rd_busy;
  logic hazard, cnt_zero, has_room, issue_ok, fire, cmt_eff;

  ysyx_issue_scoreboard #(
    .REG_LEN (REG_LEN)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .set_en   (fire && (in_rd != '0)),
    .set_idx  (in_rd),
    .clr_en   (wb_valid && (wb_rd != '0)),
    .clr_idx  (wb_rd),
    .rs1_idx  (in_rs1),
    .rs2_idx  (in_rs2),
    .rd_idx   (in_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .busy_map (busy_map)
  );

  assign hazard   = (in_use_rs1 && rs1_busy) || (in_use_rs2 && rs2_busy) || rd_busy;
  assign cnt_zero = (inflight_q == '0);
  assign has_room = (inflight_q < ISSUE_CNT_W'(MAX_INFLIGHT));

  // Reset is folded in so the handshake is quiet while reset is held low.
  assign issue_ok = reset && (state_q == IS_RUN) && !hazard && has_room &&
                    (!in_serial || cnt_zero) && !flush;

  assign out_valid = in_valid && issue_ok;
  assign in_ready  = out_ready && issue_ok;
  assign fire      = out_valid && out_ready;
  // A retire with nothing in flight is dropped rather than wrapping the counter.
  assign cmt_eff   = cmt_valid && !cnt_zero;

  always_comb begin
    inflight_d = inflight_q;
    if (fire && !cmt_eff) begin
      inflight_d = inflight_q + ISSUE_CNT_W'(1);
    end else if (!fire && cmt_eff) begin
      inflight_d = inflight_q - ISSUE_CNT_W'(1);
    end
    if (flush) inflight_d = '0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IS_RUN: begin
        if (fire && in_serial) begin
          state_d = IS_SERIAL;
        end else if (in_valid && in_serial && !cnt_zero) begin
          state_d = IS_DRAIN;
        end
      end
      IS_DRAIN: begin
        if (cnt_zero || (cmt_valid && (inflight_q == ISSUE_CNT_W'(1)))) state_d = IS_RUN;
      end
      IS_SERIAL: begin
        if (cmt_valid) state_d = IS_RUN;
      end
      default: state_d = IS_RUN;
    endcase
    if (flush) state_d = IS_RUN;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IS_RUN;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;
  assign state    = state_q;

  cmt_underflow: assert property (@(posedge clock) disable iff (!reset)
    (cmt_valid && !flush) |-> !cnt_zero)
    else $error("cmt_valid asserted with no instruction in flight");

endmodule

// File: tb/tb_ysyx_issue_ctrl.sv
module tb_ysyx_issue_ctrl;

  localparam int MaxInfl = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_use_rs1, in_use_rs2, in_serial;
  logic [3:0]  in_rs1, in_rs2, in_rd, wb_rd;
  logic        out_valid, out_ready, wb_valid, cmt_valid, flush;
  logic [15:0] busy_map;
  logic [3:0]  inflight;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  ysyx_issue_ctrl #(
    .REG_LEN      (4),
    .MAX_INFLIGHT (MaxInfl)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_use_rs1 (in_use_rs1),
    .in_use_rs2 (in_use_rs2),
    .in_rd      (in_rd),
    .in_serial  (in_serial),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .cmt_valid  (cmt_valid),
    .flush      (flush),
    .busy_map   (busy_map),
    .inflight   (inflight),
    .state      (state)
  );

  typedef struct packed {
    logic iv; logic [3:0] rs1; logic [3:0] rs2; logic u1; logic u2; logic [3:0] rd;
    logic ser; logic ordy; logic wbv; logic [3:0] wbrd; logic cmt; logic fl;
    logic e_ov; logic e_ir; logic [15:0] e_busy; logic [3:0] e_inf; logic [1:0] e_st;
  } vec_t;

  function automatic vec_t mkv(input logic iv, input int rs1, input int rs2, input logic u1,
                               input logic u2, input int rd, input logic ser, input logic ordy,
                               input logic wbv, input int wbrd, input logic cmt, input logic fl,
                               input logic e_ov, input logic e_ir, input int e_busy,
                               input int e_inf, input int e_st);
    vec_t v;
    v.iv = iv; v.rs1 = 4'(rs1); v.rs2 = 4'(rs2); v.u1 = u1; v.u2 = u2; v.rd = 4'(rd);
    v.ser = ser; v.ordy = ordy; v.wbv = wbv; v.wbrd = 4'(wbrd); v.cmt = cmt; v.fl = fl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_busy = 16'(e_busy); v.e_inf = 4'(e_inf);
    v.e_st = 2'(e_st);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic u1, input logic u2, input logic [3:0] rd, input logic ser,
                       input logic ordy, input logic wbv, input logic [3:0] wbrd,
                       input logic cmt, input logic fl);
    in_valid = iv; in_rs1 = rs1; in_rs2 = rs2; in_use_rs1 = u1; in_use_rs2 = u2;
    in_rd = rd; in_serial = ser; out_ready = ordy; wb_valid = wbv; wb_rd = wbrd;
    cmt_valid = cmt; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic run_cycle(input logic e_ov, input logic e_ir, input logic [15:0] e_busy,
                           input logic [3:0] e_inf, input logic [1:0] e_st, input string tag);
    #2;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(e_ir));
    @(posedge clock);
    #1;
    chk({tag, " busy_map"}, 32'(busy_map), 32'(e_busy));
    chk({tag, " inflight"}, 32'(inflight), 32'(e_inf));
    chk({tag, " state"}, 32'(state), 32'(e_st));
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Reference model: architectural rules, not the RTL's structure.
  bit m_busy[16];
  int m_inf;
  int m_st;   // 0 run, 1 draining before a serial op, 2 waiting for serial op to retire

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v = '0;
    for (int i = 1; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit m_can_issue();
    bit haz;
    haz = (in_use_rs1 && in_rs1 != 0 && m_busy[in_rs1]) ||
          (in_use_rs2 && in_rs2 != 0 && m_busy[in_rs2]) ||
          (in_rd != 0 && m_busy[in_rd]);
    return (m_st == 0) && !haz && (m_inf < MaxInfl) && (!in_serial || m_inf == 0) && !flush;
  endfunction

  task automatic m_step(input bit fire);
    int new_inf;
    if (flush) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_inf = 0;
      m_st  = 0;
    end else begin
      new_inf = m_inf + (fire ? 1 : 0) - ((cmt_valid && m_inf > 0) ? 1 : 0);
      case (m_st)
        0: if (fire && in_serial) m_st = 2;
           else if (in_valid && in_serial && m_inf != 0) m_st = 1;
        1: if (new_inf == 0) m_st = 0;
        default: if (cmt_valid) m_st = 0;
      endcase
      if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 0;
      if (fire && in_rd != 0) m_busy[in_rd] = 1;
      m_inf = new_inf;
    end
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = mkv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 'h0002, 1, 0);
    tbl[1]  = mkv(1, 3, 0, 1, 0, 2, 0, 1, 0, 0, 0, 0, 1, 1, 'h0006, 2, 0);
    tbl[2]  = mkv(1, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 1, 1, 'h0026, 3, 0);
    tbl[3]  = mkv(1, 5, 0, 1, 0, 5, 0, 1, 1, 1, 1, 0, 0, 0, 'h0024, 2, 0);
    tbl[4]  = mkv(1, 5, 0, 1, 0, 5, 0, 1, 1, 5, 0, 0, 0, 0, 'h0004, 2, 0);
    tbl[5]  = mkv(1, 5, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 1, 1, 'h0024, 3, 0);
    tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 0, 1, 'h0020, 2, 0);
    tbl[7]  = mkv(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, 'h0020, 2, 1);
    tbl[8]  = mkv(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 1, 0, 0, 0, 'h0020, 1, 1);
    tbl[9]  = mkv(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 1, 0, 0, 0, 'h0020, 0, 0);
    tbl[10] = mkv(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 1, 1, 'h0060, 1, 2);
    tbl[11] = mkv(1, 0, 0, 0, 0, 7, 0, 1, 0, 0, 1, 0, 0, 0, 'h0060, 0, 0);
    tbl[12] = mkv(1, 0, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0, 1, 1, 'h00E0, 1, 0);
    tbl[13] = mkv(1, 0, 0, 0, 0, 8, 0, 1, 1, 5, 1, 1, 0, 0, 'h0000, 0, 0);

    // Reset held from time 0 with a ready instruction waiting: handshake must stay low.
    reset = 1'b0;
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    chk("reset busy_map", 32'(busy_map), 32'd0);
    chk("reset inflight", 32'(inflight), 32'd0);
    chk("reset state", 32'(state), 32'd0);
    reset = 1'b1;
    idle();
    @(posedge clock);
    #1;

    // Directed table: back-to-back, RAW stall, serial drain, flush.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].ser,
            tbl[i].ordy, tbl[i].wbv, tbl[i].wbrd, tbl[i].cmt, tbl[i].fl);
      run_cycle(tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_busy, tbl[i].e_inf, tbl[i].e_st,
                $sformatf("tbl[%0d]", i));
    end

    // Full counter: four fires, fifth blocked, then commit-only and fire+commit.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
      run_cycle(1'b1, 1'b1, 16'h0, 4'(i + 1), 2'd0, $sformatf("full fire%0d", i));
    end
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 16'h0, 4'd4, 2'd0, "full blocked");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 16'h0, 4'd3, 2'd0, "full cmt at max");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    run_cycle(1'b1, 1'b1, 16'h0, 4'd3, 2'd0, "full fire+cmt");

    // Flush mid-DRAIN with busy_map=0x0022, inflight=3.
    pulse_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 16'h0002, 4'd1, 2'd0, "fl issue1");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 16'h0022, 4'd2, 2'd0, "fl issue2");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 16'h0022, 4'd3, 2'd0, "fl issue3");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b0, 16'h0022, 4'd3, 2'd1, "fl to drain");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1);
    run_cycle(1'b0, 1'b0, 16'h0000, 4'd0, 2'd0, "fl flush");
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 16'h0008, 4'd1, 2'd0, "fl pending issues");

    // Async reset pulse between edges while SERIAL.
    pulse_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 16'h0010, 4'd1, 2'd2, "ar serial fire");
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    chk("ar blocked in serial", 32'(out_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("ar busy_map", 32'(busy_map), 32'd0);
    chk("ar inflight", 32'(inflight), 32'd0);
    chk("ar state", 32'(state), 32'd0);
    chk("ar out_valid", 32'(out_valid), 32'd0);
    chk("ar in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("ar released out_valid", 32'(out_valid), 32'd1);
    @(posedge clock);
    #1;
    chk("ar post busy_map", 32'(busy_map), 32'h0080);
    chk("ar post inflight", 32'(inflight), 32'd1);
    chk("ar post state", 32'(state), 32'd0);

    // Randomised traffic against the reference model.
    pulse_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_inf = 0;
    m_st  = 0;
    for (int c = 0; c < 1500; c++) begin
      bit ok;
      bit exp_ov;
      bit exp_ir;
      drive(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 4'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 7)),
            (m_inf > 0) && ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 2));
      ok     = m_can_issue();
      exp_ov = in_valid && ok;
      exp_ir = out_ready && ok;
      m_step(exp_ov && out_ready);
      run_cycle(exp_ov, exp_ir, m_busy_vec(), 4'(m_inf), 2'(m_st),
                $sformatf("rand[%0d]", c));
      chk("x0 never busy", 32'(busy_map[0]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
